mem_scan_reader: RTL and testbench
==================================

MEM_SCAN_READER -- requirements
Module: mem_scan_reader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk (single clock) and clr (reset, asserted when 0, sampled on the rising clk edge).
REQ-002 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 15, memory address width.
- DATA_W, 18, memory read-data width.
- BASE_ADDR, 0, first address scanned.
- LAST_ADDR, 23, last address scanned.
- HOLD_CYCLES, 50000000, dwell per word in auto mode.
- DEB_CYCLES, 1000000, button stable time.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- clr, in, 1, active-low synchronous reset.
- start, in, 1, begin scan.
- stop, in, 1, abort scan.
- mode, in, 1, 0 = auto-advance, 1 = button-step.
- button, in, 1, raw asynchronous pushbutton.
- rdata, in, DATA_W, memory read data, registered with 1-cycle latency.
- addr, out, ADDR_W, memory read address.
- rd_en, out, 1, read strobe.
- display, out, 16, captured word rdata[15:0].
- disp_valid, out, 1, display holds scanned data.
- busy, out, 1, scan active.
- wrapped, out, 1, one-cycle pulse on wrap from LAST_ADDR to BASE_ADDR.
- ovf, out, 1, see REQ-017.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and HOLD.
REQ-005 In IDLE, start=1 and stop=0 SHALL move the FSM to ISSUE; start is ignored in every other state.
REQ-006 ISSUE SHALL drive rd_en=1 with the current addr for exactly one cycle, then go to WAIT.
REQ-007 WAIT SHALL last one cycle; on leaving it, the block SHALL load display with rdata[15:0], set disp_valid=1 and enter HOLD.
REQ-008 The latency from the edge that samples start to the edge that updates display SHALL be exactly 3 clocks.
REQ-009 In HOLD with mode=0, the block SHALL count HOLD_CYCLES clocks and then advance.
REQ-010 In HOLD with mode=1, the block SHALL advance on a debounced button rising-edge pulse.
REQ-011 Mode SHALL be sampled on every HOLD cycle.
REQ-012 On advance, addr SHALL become addr+1 and the FSM SHALL go to ISSUE.
REQ-013 If addr equals LAST_ADDR on advance, addr SHALL become BASE_ADDR, wrapped SHALL pulse for one cycle, and the scan SHALL continue.
REQ-014 stop=1 in any state SHALL force IDLE on the next edge, with addr, display and disp_valid held; stop SHALL take priority over start and over an advance in the same cycle.
REQ-015 The button SHALL pass through a 2-flop synchronizer; the debounced level SHALL change only after the synchronized input has been stable for DEB_CYCLES consecutive clocks; the step pulse is one cycle on a 0->1 change of the debounced level.
REQ-016 A step pulse outside HOLD, or in HOLD with mode=0, SHALL be discarded and not queued; busy SHALL be 1 in every state except IDLE; rd_en SHALL be 0 outside ISSUE.

Reset
REQ-017 With clr=0, the following SHALL apply on the next edge, overriding all inputs:
- state = IDLE.
- addr = BASE_ADDR.
- display = 0.
- disp_valid, rd_en, busy, wrapped, ovf = 0.
- HOLD counter and debounce counter cleared; debounced level = 0.
A reset mid-scan SHALL abandon the read in flight.

Configuration
REQ-018 With macro MEM_SCAN_OVF_EN defined, ovf SHALL be loaded with the OR of rdata[DATA_W-1:16] at the same edge that loads display; without the macro, ovf SHALL be constant 0 and no capture logic SHALL exist.

Structure
REQ-019 The FSM state encoding and the default parameter constants SHALL live in shared package mem_scan_pkg.
REQ-020 The synchronizer and debouncer SHALL be a single sub-module, btn_debounce, with ports clk, clr, btn_raw, btn_level and btn_rise, instantiated once.

Verification (HOLD_CYCLES=4, DEB_CYCLES=3, BASE_ADDR=0, LAST_ADDR=3, memory model returns 16'h1000+addr)
REQ-021 Auto scan: start pulse at cycle 0 with mode=0 -> display=16'h1000 at cycle 3, then 16'h1001 at cycle 10; rd_en high only in ISSUE.
REQ-022 Wrap: run auto scan past addr 3 -> wrapped pulses once, then addr=0 and display=16'h1000.
REQ-023 Step mode: a clean button press of 5 cycles -> exactly one advance; a 2-cycle glitch -> no advance; a press during WAIT -> ignored.
REQ-024 Priority: stop and start high together in IDLE -> stays in IDLE; stop in HOLD on the count-terminal cycle -> IDLE, addr unchanged.
REQ-025 Reset mid-scan: clr=0 in WAIT -> next cycle state IDLE, display=0, disp_valid=0, addr=0.
REQ-026 With MEM_SCAN_OVF_EN: rdata=18'h2_0005 -> ovf=1 and display=16'h0005; without the macro, ovf=0.

Source files
------------

// File: rtl/mem_scan_pkg.sv
// Shared state encoding and default parameter values for the memory scan reader.
package mem_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W      = 15;
  localparam int DEF_DATA_W      = 18;
  localparam int DEF_BASE_ADDR   = 0;
  localparam int DEF_LAST_ADDR   = 23;
  localparam int DEF_HOLD_CYCLES = 50000000;
  localparam int DEF_DEB_CYCLES  = 1000000;

endpackage

// File: rtl/mem_scan_reader_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability-count debouncer and
// one-cycle rising-edge pulse on the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips only once the synchronized input has disagreed with it
  // for DEB_CYCLES consecutive clocks; any agreement restarts the count.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;

endmodule

// File: rtl/mem_scan_reader.sv
// Scans a memory range, showing each word on a 16-bit display, advancing on a
// dwell timer or a debounced button. Define MEM_SCAN_OVF_EN to capture ovf.
module mem_scan_reader
  import mem_scan_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int LAST_ADDR   = DEF_LAST_ADDR,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic              button,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  output logic [15:0]       display,
  output logic              disp_valid,
  output logic              busy,
  output logic              wrapped,
  output logic              ovf
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       display_q, display_d;
  logic              disp_valid_q, disp_valid_d;
  logic              wrapped_q, wrapped_d;
  logic              start_q, start_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              advance;
  logic              step_pulse;
  logic              deb_level_unused;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .clr      (clr),
    .btn_raw  (button),
    .btn_level(deb_level_unused),
    .btn_rise (step_pulse)
  );

  // start is registered in IDLE only, giving a fixed three-clock path to the
  // first display update; stop overrides every transition and freezes data.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    display_d    = display_q;
    disp_valid_d = disp_valid_q;
    wrapped_d    = 1'b0;
    start_d      = start & ~stop & (state_q == IDLE);
    hold_cnt_d   = '0;
    advance      = 1'b0;
    case (state_q)
      IDLE:  if (start_q) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d      = HOLD;
        display_d    = rdata[15:0];
        disp_valid_d = 1'b1;
      end
      HOLD: begin
        if (mode) begin
          advance = step_pulse;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES)) begin
          advance = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        if (advance) begin
          state_d = ISSUE;
          if (addr_q == ADDR_W'(LAST_ADDR)) begin
            addr_d    = ADDR_W'(BASE_ADDR);
            wrapped_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d      = IDLE;
      addr_d       = addr_q;
      display_d    = display_q;
      disp_valid_d = disp_valid_q;
      wrapped_d    = 1'b0;
      hold_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= IDLE;
      addr_q       <= ADDR_W'(BASE_ADDR);
      display_q    <= '0;
      disp_valid_q <= 1'b0;
      wrapped_q    <= 1'b0;
      start_q      <= 1'b0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      display_q    <= display_d;
      disp_valid_q <= disp_valid_d;
      wrapped_q    <= wrapped_d;
      start_q      <= start_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

`ifdef MEM_SCAN_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == WAIT && !stop) ovf_d = |rdata[DATA_W-1:16];
  end

  always_ff @(posedge clk) begin
    if (!clr) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic rdata_hi_unused;
  assign rdata_hi_unused = |rdata[DATA_W-1:16];
  assign ovf             = 1'b0;
`endif

  assign addr       = addr_q;
  assign rd_en      = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign display    = display_q;
  assign disp_valid = disp_valid_q;
  assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_mem_scan_reader.sv
// Directed bench for mem_scan_reader with a display scoreboard and a
// registered memory model returning 16'h1000 + addr.
module tb_mem_scan_reader;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic        button = 1'b0;
  logic [17:0] rdata = '0;
  logic [14:0] addr;
  logic        rd_en;
  logic [15:0] display;
  logic        disp_valid;
  logic        busy;
  logic        wrapped;
  logic        ovf;

  logic        mem_ovf = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] sbq[$];
  int          rd_cnt;
  logic [14:0] m_addr;
  logic [14:0] old_addr;
  logic        exp_wrap;

  mem_scan_reader #(
    .ADDR_W     (15),
    .DATA_W     (18),
    .BASE_ADDR  (0),
    .LAST_ADDR  (3),
    .HOLD_CYCLES(4),
    .DEB_CYCLES (3)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .button    (button),
    .rdata     (rdata),
    .addr      (addr),
    .rd_en     (rd_en),
    .display   (display),
    .disp_valid(disp_valid),
    .busy      (busy),
    .wrapped   (wrapped),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rdata <= mem_ovf ? 18'h20005 : (18'h01000 + 18'(addr));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic m, input logic b);
    start  = s;
    stop   = p;
    mode   = m;
    button = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic popCompare(input string tag);
    logic [15:0] exp;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=<scoreboard empty>", tag, display);
    end else begin
      exp = sbq.pop_front();
      checkOutput(tag, display, exp);
      checkOutput({tag, "_valid"}, disp_valid, 1);
    end
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(0, 0, 0, 0);
    clr = 1'b0;
    tick(3);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_display", display, 0);
    checkOutput("rst_disp_valid", disp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_wrapped", wrapped, 0);
    checkOutput("rst_ovf", ovf, 0);
    clr = 1'b1;
    tick();

    // Auto scan across the wrap, then stop on the dwell terminal cycle.
    m_addr = 0;
    applyStimulus(1, 0, 0, 0);
    tick();
    start = 1'b0;
    checkOutput("start_busy_c0", busy, 0);
    checkOutput("start_rd_en_c0", rd_en, 0);
    for (int c = 1; c <= 35; c++) begin
      tick();
      exp_wrap = 1'b0;
      if (c > 1 && (c - 1) % 7 == 0) begin
        old_addr = m_addr;
        m_addr   = (m_addr == 15'd3) ? 15'd0 : m_addr + 15'd1;
        exp_wrap = (old_addr == 15'd3);
      end
      if ((c - 1) % 7 == 0) sbq.push_back(16'h1000 + 16'(m_addr));
      checkOutput("auto_rd_en", rd_en, ((c - 1) % 7 == 0));
      checkOutput("auto_addr", addr, m_addr);
      checkOutput("auto_wrapped", wrapped, exp_wrap);
      checkOutput("auto_busy", busy, 1);
      if (c == 2) begin
        checkOutput("lat_display_not_early", display, 0);
        checkOutput("lat_valid_not_early", disp_valid, 0);
      end
      if (c >= 3 && (c - 3) % 7 == 0) popCompare("auto_display");
      if (c == 35) stop = 1'b1;
    end
    tick();
    stop = 1'b0;
    checkOutput("stop_term_busy", busy, 0);
    checkOutput("stop_term_addr", addr, 0);
    checkOutput("stop_term_display", display, 16'h1000);
    checkOutput("stop_term_valid", disp_valid, 1);
    checkOutput("stop_term_rd_en", rd_en, 0);

    // stop beats start in IDLE.
    applyStimulus(1, 1, 0, 0);
    tick(2);
    applyStimulus(0, 0, 0, 0);
    tick(2);
    checkOutput("prio_busy", busy, 0);
    checkOutput("prio_rd_en", rd_en, 0);

    // Step mode; this read returns 18'h20005 to exercise ovf.
    mem_ovf = 1'b1;
    applyStimulus(1, 0, 1, 0);
    sbq.push_back(16'h0005);
    tick();
    start = 1'b0;
    tick(2);
    mem_ovf = 1'b0;
    tick();
    popCompare("ovf_display");
`ifdef MEM_SCAN_OVF_EN
    checkOutput("ovf_set", ovf, 1);
`else
    checkOutput("ovf_off", ovf, 0);
`endif

    // Two-cycle glitch must not step.
    button = 1'b1;
    tick(2);
    button = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rd_cnt += int'(rd_en);
    end
    checkOutput("glitch_reads", rd_cnt, 0);
    checkOutput("glitch_addr", addr, 0);
    checkOutput("glitch_busy", busy, 1);

    // Clean five-cycle press steps exactly once.
    button = 1'b1;
    sbq.push_back(16'h1001);
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 4) button = 1'b0;
      rd_cnt += int'(rd_en);
    end
    checkOutput("press_reads", rd_cnt, 1);
    checkOutput("press_addr", addr, 1);
    popCompare("press_display");

    // Press timed so the debounced pulse lands in WAIT: discarded.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    button = 1'b1;
    tick(2);
    start = 1'b1;
    sbq.push_back(16'h1001);
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      if (i == 2) begin
        button = 1'b0;
        checkOutput("wait_press_rd_en", rd_en, 0);
        checkOutput("wait_press_busy", busy, 1);
      end
      if (i == 3) popCompare("wait_press_display");
      rd_cnt += int'(rd_en);
    end
    checkOutput("wait_press_reads", rd_cnt, 1);
    checkOutput("wait_press_addr", addr, 1);

    // Reset while in WAIT abandons the read.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("mid_issue_rd_en", rd_en, 1);
    tick();
    checkOutput("mid_wait_rd_en", rd_en, 0);
    checkOutput("mid_wait_busy", busy, 1);
    clr = 1'b0;
    tick();
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_display", display, 0);
    checkOutput("mid_rst_valid", disp_valid, 0);
    checkOutput("mid_rst_addr", addr, 0);
    checkOutput("mid_rst_rd_en", rd_en, 0);
    checkOutput("mid_rst_ovf", ovf, 0);
    clr = 1'b1;
    tick(2);
    checkOutput("mid_rst_stays_idle", busy, 0);
    checkOutput("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
